vga_line_prefetch: RTL and testbench
====================================

Name: vga_line_prefetch

Overview:
- Sits between the shared SRAM read port and the VGA pixel output stage.
- Prefetches 1bpp framebuffer scanlines into a two-bank line buffer, so the pixel stream never waits on SRAM_busy.
- Delivers one pixel per pix_en strobe from the active bank, MSB-first within each 32-bit word.
- Flags underrun when the display reaches a bank that is not yet filled.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- WORDS_PER_LINE, 20, 32-bit words per line (H_ACTIVE/32).
- BASE_ADDR, 0, word address of line 0, word 0.

Ports:
- clk  in  1  system clock (25 MHz pixel clock).
- nrst  in  1  reset; synchronous, active-high (nrst=1 at a posedge resets the block). Port name follows codebase convention; polarity is fixed as stated.
- frame_start  in  1  one-cycle pulse during vertical blanking; restarts the frame.
- pix_en  in  1  consume one active pixel this cycle.
- SRAM_data_in  in  32  read data, valid in the accept cycle.
- SRAM_busy  in  1  SRAM cannot accept a read this cycle.
- data_en  out  1  read request.
- word_address_dest  out  32  word address of the request.
- byte_select  out  4  always 4'hF.
- pixel_data  out  1  registered pixel.
- underrun  out  1  sticky; cleared by frame_start or reset.
- fetch_state  out  2  0 IDLE, 1 FETCH, 2 FULL.
- bank_valid  out  2  per-bank filled flags.

Behaviour:
Reset (nrst=1):
- data_en=0, word_address_dest=0, byte_select=4'hF, pixel_data=0, underrun=0.
- fetch_state=IDLE, bank_valid=2'b00.
- fetch_line=0, disp_line=0, wr_bank=0, rd_bank=0, word_idx=0, bit_idx=0.
- Reset mid-fetch abandons the request in the same cycle; no buffer write occurs.

frame_start (takes priority over every other event in the same cycle):
- Performs the same clears as reset, except byte_select, which stays 4'hF.
- Then enters FETCH next cycle.

Fetch FSM:
- IDLE: moves to FETCH when bank_valid[wr_bank]=0 and fetch_line<V_ACTIVE.
- FETCH: data_en=1; word_address_dest = BASE_ADDR + fetch_line*WORDS_PER_LINE + word_idx (32-bit arithmetic, no wrap).
- Accept = data_en & ~SRAM_busy at posedge. On accept, SRAM_data_in is written to bank[wr_bank][word_idx] and word_idx increments.
- Accept with word_idx=WORDS_PER_LINE-1:
  - sets bank_valid[wr_bank], toggles wr_bank, increments fetch_line, clears word_idx;
  - next state is FETCH if the new wr_bank is empty and fetch_line<V_ACTIVE, else FULL, or IDLE if fetch_line=V_ACTIVE.
- SRAM_busy=1 holds data_en and address stable; unlimited stall.
- FULL: data_en=0; returns to FETCH the cycle after bank_valid[wr_bank] clears.

Display side:
- pix_en=1: pixel_data(next cycle) = bank[rd_bank][word_idx_rd][31-bit_idx] if bank_valid[rd_bank], else 0.
- Read index: bit_idx counts 0..31, then word_idx_rd increments.
- 640th pix_en of a line: clears bank_valid[rd_bank], toggles rd_bank, increments disp_line, resets the read indices.
- pix_en=0: pixel_data holds its value.
- Latency from pix_en to pixel_data is 1 cycle.

Underrun:
- pix_en while bank_valid[rd_bank]=0 sets underrun. Output is 0 and the read counters still advance.
- The line end still toggles rd_bank.

Same-cycle events:
- Fetch completing into a bank while the display frees the other bank: both take effect; no lost update.
- Display frees the bank the fetcher waits on: FULL→FETCH on the next cycle.
- pix_en beyond V_ACTIVE lines: treated as underrun.

Test Plan:
1. Reset → all outputs at reset values. Release, pulse frame_start, SRAM_busy=0 → data_en high for 20 cycles at addresses 0..19, then 20..39. After 40 accepts: bank_valid=2'b11, fetch_state=FULL.
2. Memory word0=32'h80000001, pix_en for 32 cycles → pixel_data sequence 1, then 0×30, then 1, each 1 cycle after pix_en.
3. SRAM_busy high 5 cycles mid-fetch at word 7 → address holds at 7 throughout, no skipped or duplicated word, bank contents match memory.
4. 640 pix_en after full prefetch → bank_valid[0] clears, refetch of line 2 at addresses 40..59 starts the following cycle, underrun stays 0.
5. pix_en immediately after frame_start, before any accept → pixel_data=0, underrun=1. A second frame_start clears underrun.
6. nrst=1 for 1 cycle during FETCH at word 10 → data_en=0 next cycle. After frame_start, refetch restarts at address 0.

Source files
------------

// File: rtl/vga_line_prefetch_if.sv
// SRAM read-port bundle between the line prefetcher and the shared SRAM.
// master: data_en, word_address_dest, byte_select out; SRAM_data_in, SRAM_busy in.
interface vga_line_prefetch_if;
    logic        data_en;
    logic [31:0] word_address_dest;
    logic [3:0]  byte_select;
    logic [31:0] SRAM_data_in;
    logic        SRAM_busy;

    modport master (
        output data_en, word_address_dest, byte_select,
        input  SRAM_data_in, SRAM_busy
    );

    modport slave (
        input  data_en, word_address_dest, byte_select,
        output SRAM_data_in, SRAM_busy
    );
endinterface

// File: rtl/vga_line_prefetch.sv
// Two-bank 1bpp scanline prefetcher feeding the VGA pixel stage.
// Ports: clk, nrst (sync, active-high), frame_start, pix_en, SRAM bus (master),
// pixel_data, underrun (sticky), fetch_state, bank_valid.
module vga_line_prefetch #(
    parameter int          H_ACTIVE       = 640,
    parameter int          V_ACTIVE       = 480,
    parameter int          WORDS_PER_LINE = 20,
    parameter logic [31:0] BASE_ADDR      = 32'd0
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                frame_start,
    input  logic                pix_en,
    vga_line_prefetch_if.master bus,
    output logic                pixel_data,
    output logic                underrun,
    output logic [1:0]          fetch_state,
    output logic [1:0]          bank_valid
);
    localparam int WW        = $clog2(WORDS_PER_LINE);
    localparam int LW        = $clog2(V_ACTIVE + 1);
    localparam int LAST_WORD = H_ACTIVE / 32 - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     mem [2][WORDS_PER_LINE];
    logic            wr_bank;
    logic            rd_bank;
    logic [WW-1:0]   word_idx;
    logic [WW-1:0]   rd_word;
    logic [4:0]      bit_idx;
    logic [LW-1:0]   fetch_line;
    logic [LW-1:0]   disp_line;

    logic            accept;
    logic            last_fetch;
    logic            fill_done;
    logic            line_end;
    logic            rd_ok;
    logic [1:0]      nbv;
    logic [LW-1:0]   line_nx;

    function automatic logic [31:0] addr_of(input logic [LW-1:0] line,
                                            input logic [WW-1:0] w);
        return BASE_ADDR + 32'(line) * 32'(WORDS_PER_LINE) + 32'(w);
    endfunction

    assign fetch_state     = state;
    assign bus.byte_select = 4'hF;

    // nbv merges the display-side free and the fetch-side fill of this
    // cycle so neither update is lost and the FSM reacts to both at once.
    always_comb begin
        accept     = bus.data_en & ~bus.SRAM_busy;
        last_fetch = (word_idx == WW'(WORDS_PER_LINE - 1));
        fill_done  = accept & last_fetch;
        line_end   = pix_en & (rd_word == WW'(LAST_WORD)) & (bit_idx == 5'd31);
        rd_ok      = bank_valid[rd_bank] & (disp_line < LW'(V_ACTIVE));
        line_nx    = fetch_line + LW'(1);
        nbv        = bank_valid;
        if (line_end)  nbv[rd_bank] = 1'b0;
        if (fill_done) nbv[wr_bank] = 1'b1;
    end

    // Buffer write is suppressed by reset and frame_start in the same cycle.
    always_ff @(posedge clk) begin
        if (!nrst && !frame_start && accept)
            mem[wr_bank][word_idx] <= bus.SRAM_data_in;
    end

    always_ff @(posedge clk) begin
        if (nrst || frame_start) begin
            state                 <= IDLE;
            bus.data_en           <= 1'b0;
            bus.word_address_dest <= 32'd0;
            bank_valid            <= 2'b00;
            wr_bank               <= 1'b0;
            rd_bank               <= 1'b0;
            word_idx              <= '0;
            rd_word               <= '0;
            bit_idx               <= '0;
            fetch_line            <= '0;
            disp_line             <= '0;
            pixel_data            <= 1'b0;
            underrun              <= 1'b0;
        end else begin
            bank_valid <= nbv;

            unique case (state)
                IDLE: begin
                    if (!nbv[wr_bank] && fetch_line < LW'(V_ACTIVE)) begin
                        state                 <= FETCH;
                        bus.data_en           <= 1'b1;
                        bus.word_address_dest <= addr_of(fetch_line, word_idx);
                    end
                end
                FETCH: begin
                    if (accept && last_fetch) begin
                        wr_bank    <= ~wr_bank;
                        fetch_line <= line_nx;
                        word_idx   <= '0;
                        if (line_nx == LW'(V_ACTIVE)) begin
                            state       <= IDLE;
                            bus.data_en <= 1'b0;
                        end else if (!nbv[~wr_bank]) begin
                            bus.word_address_dest <= addr_of(line_nx, '0);
                        end else begin
                            state       <= FULL;
                            bus.data_en <= 1'b0;
                        end
                    end else if (accept) begin
                        word_idx              <= word_idx + WW'(1);
                        bus.word_address_dest <= addr_of(fetch_line,
                                                         word_idx + WW'(1));
                    end
                end
                FULL: begin
                    if (!nbv[wr_bank]) begin
                        state                 <= FETCH;
                        bus.data_en           <= 1'b1;
                        bus.word_address_dest <= addr_of(fetch_line, word_idx);
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.data_en <= 1'b0;
                end
            endcase

            // Read counters advance even on underrun to keep raster alignment.
            if (pix_en) begin
                pixel_data <= rd_ok ? mem[rd_bank][rd_word][5'd31 - bit_idx]
                                    : 1'b0;
                if (!rd_ok) underrun <= 1'b1;
                bit_idx <= bit_idx + 5'd1;
                if (bit_idx == 5'd31) begin
                    if (rd_word == WW'(LAST_WORD)) begin
                        rd_word <= '0;
                        rd_bank <= ~rd_bank;
                        if (disp_line < LW'(V_ACTIVE))
                            disp_line <= disp_line + LW'(1);
                    end else begin
                        rd_word <= rd_word + WW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_line_prefetch.sv
// Self-checking bench for vga_line_prefetch: vector table, directed corner
// sequences and a randomized run against a frame-level pixel/address model.
module tb_vga_line_prefetch;
    logic       clk = 1'b0;
    logic       nrst;
    logic       frame_start;
    logic       pix_en;
    logic       pixel_data;
    logic       underrun;
    logic [1:0] fetch_state;
    logic [1:0] bank_valid;

    vga_line_prefetch_if bus ();

    vga_line_prefetch dut (
        .clk         (clk),
        .nrst        (nrst),
        .frame_start (frame_start),
        .pix_en      (pix_en),
        .bus         (bus),
        .pixel_data  (pixel_data),
        .underrun    (underrun),
        .fetch_state (fetch_state),
        .bank_valid  (bank_valid)
    );

    always #5 clk = ~clk;

    // Framebuffer image: 480 lines x 20 words.
    logic [31:0] img [9600];

    always_comb begin
        bus.SRAM_data_in = 32'h0;
        if (bus.word_address_dest < 32'd9600)
            bus.SRAM_data_in = img[bus.word_address_dest[13:0]];
    end

    int   checks = 0;
    int   errors = 0;
    int   exp_addr;
    int   pix_count;
    logic exp_pixel;

    typedef struct {
        logic pe;
        logic px;
        logic ur;
    } vec_t;
    vec_t vecs [38];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pixel n of the frame: raster order, MSB-first inside each word.
    function automatic logic model_pix(input int n);
        int          line;
        int          w;
        int          b;
        logic [31:0] word;
        line = n / 640;
        w    = (n % 640) / 32;
        b    = n % 32;
        word = img[line * 20 + w];
        return word[31 - b];
    endfunction

    // One cycle: fetch addresses must form the gapless sequence 0,1,2,...
    task automatic step(input logic pe, input logic bz);
        pix_en        = pe;
        bus.SRAM_busy = bz;
        if (bus.data_en && !bz) begin
            check("fetch_addr", bus.word_address_dest, exp_addr);
            exp_addr++;
        end
        if (pe) begin
            exp_pixel = model_pix(pix_count);
            pix_count++;
        end
        tick();
        check("pixel", 32'(pixel_data), 32'(exp_pixel));
    endtask

    initial begin
        int cyc;
        bit timeout;

        foreach (img[i]) img[i] = $urandom;
        img[0] = 32'h8000_0001;
        img[1] = 32'hC000_0000;

        vecs[0] = '{1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0};
        for (int i = 2; i < 32; i++) vecs[i] = '{1'b1, 1'b0, 1'b0};
        vecs[32] = '{1'b0, 1'b0, 1'b0};
        vecs[33] = '{1'b1, 1'b1, 1'b0};
        vecs[34] = '{1'b0, 1'b1, 1'b0};
        vecs[35] = '{1'b1, 1'b1, 1'b0};
        vecs[36] = '{1'b1, 1'b1, 1'b0};
        vecs[37] = '{1'b1, 1'b0, 1'b0};

        nrst          = 1'b1;
        frame_start   = 1'b0;
        pix_en        = 1'b0;
        bus.SRAM_busy = 1'b0;
        repeat (3) tick();

        check("rst_data_en", 32'(bus.data_en), 0);
        check("rst_addr", bus.word_address_dest, 0);
        check("rst_bytesel", 32'(bus.byte_select), 32'hF);
        check("rst_pixel", 32'(pixel_data), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_state", 32'(fetch_state), 0);
        check("rst_bank_valid", 32'(bank_valid), 0);

        // Initial fill: 40 back-to-back accepts, then FULL.
        nrst        = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_state", 32'(fetch_state), 0);
        check("fs_data_en", 32'(bus.data_en), 0);
        exp_addr  = 0;
        pix_count = 0;
        exp_pixel = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) begin
            check("fill_data_en", 32'(bus.data_en), 1);
            check("fill_addr", bus.word_address_dest, i);
            step(1'b0, 1'b0);
        end
        check("fill_state", 32'(fetch_state), 2);
        check("fill_bank_valid", 32'(bank_valid), 32'h3);
        check("fill_data_en_off", 32'(bus.data_en), 0);

        // Vector table over words 0 and 1 of line 0, with hold cycles.
        foreach (vecs[i]) begin
            pix_en = vecs[i].pe;
            tick();
            check("vec_pixel", 32'(pixel_data), 32'(vecs[i].px));
            check("vec_underrun", 32'(underrun), 32'(vecs[i].ur));
            if (vecs[i].pe) pix_count++;
            exp_pixel = vecs[i].px;
        end

        // Rest of line 0; the 640th pixel frees bank 0 and refetch starts.
        while (pix_count < 640) step(1'b1, 1'b0);
        pix_en = 1'b0;
        check("eol_bank_valid", 32'(bank_valid), 32'h2);
        check("eol_state", 32'(fetch_state), 1);
        check("eol_data_en", 32'(bus.data_en), 1);
        check("eol_addr", bus.word_address_dest, 40);
        check("eol_underrun", 32'(underrun), 0);

        // Stall at word 7 of line 2 for 5 cycles.
        repeat (7) step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            check("stall_data_en", 32'(bus.data_en), 1);
            check("stall_addr", bus.word_address_dest, 47);
        end
        repeat (13) step(1'b0, 1'b0);
        check("refill_state", 32'(fetch_state), 2);
        check("refill_bank_valid", 32'(bank_valid), 32'h3);

        // Randomized display of lines 1..3 with random SRAM stalls.
        cyc = 0;
        while (pix_count < 2560 && cyc < 8000) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            cyc++;
        end
        pix_en        = 1'b0;
        bus.SRAM_busy = 1'b0;
        check("rand_complete", 32'(pix_count >= 2560), 1);
        check("rand_underrun", 32'(underrun), 0);

        // Underrun right after frame_start, cleared by the next frame_start.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pix_en      = 1'b1;
        tick();
        pix_en = 1'b0;
        check("ur_pixel", 32'(pixel_data), 0);
        check("ur_set", 32'(underrun), 1);
        tick();
        check("ur_sticky", 32'(underrun), 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("ur_cleared", 32'(underrun), 0);
        check("ur_bank_valid", 32'(bank_valid), 0);
        exp_addr  = 0;
        pix_count = 0;
        exp_pixel = 1'b0;

        // Reset in the middle of a line fetch at word 10.
        timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.data_en && bus.word_address_dest == 32'd10) begin
                timeout = 1'b0;
                break;
            end
            step(1'b0, 1'b0);
        end
        check("wait_word10", 32'(timeout), 0);
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        check("midrst_data_en", 32'(bus.data_en), 0);
        check("midrst_state", 32'(fetch_state), 0);
        check("midrst_bank_valid", 32'(bank_valid), 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_addr    = 0;
        timeout     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.data_en) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        check("wait_refetch", 32'(timeout), 0);
        check("refetch_addr", bus.word_address_dest, 0);
        repeat (20) step(1'b0, 1'b0);
        check("refetch_bank_valid", 32'(bank_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
